// File: rtl/rgb2luma_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : rgb2luma_pipe
//  Description : Three-stage RGB to luma converter with selectable weights,
//                per-beat mode/coefficients, user sideband, global stall
//                enable and a saturating count of clipped output beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb2luma_pipe #(
   parameter int WIDTH_P  = 8,
   parameter int FRAC_P   = 8,
   parameter int USER_W_P = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [WIDTH_P-1:0]  red_i,
   input  logic [WIDTH_P-1:0]  green_i,
   input  logic [WIDTH_P-1:0]  blue_i,
   input  logic [USER_W_P-1:0] user_i,
   input  logic [1:0]          mode_i,
   input  logic [FRAC_P:0]     coef_r_i,
   input  logic [FRAC_P:0]     coef_g_i,
   input  logic [FRAC_P:0]     coef_b_i,
   output logic                valid_o,
   input  logic                ready_i,
   output logic [WIDTH_P-1:0]  gray_o,
   output logic [USER_W_P-1:0] user_o,
   output logic [15:0]         sat_cnt_o
);

   localparam int c_PROD_W = WIDTH_P + FRAC_P + 1;
   localparam int c_SUM_W  = WIDTH_P + FRAC_P + 3;
   localparam int c_ONE    = 1 << FRAC_P;

   // Red and green are rounded to nearest; blue absorbs the remainder so each
   // fixed set sums to exactly one (all-max input then maps to full scale).
   localparam logic [FRAC_P:0] c_601_R = (FRAC_P+1)'((299 * c_ONE + 500) / 1000);
   localparam logic [FRAC_P:0] c_601_G = (FRAC_P+1)'((587 * c_ONE + 500) / 1000);
   localparam logic [FRAC_P:0] c_601_B = (FRAC_P+1)'(c_ONE - int'(c_601_R) - int'(c_601_G));
   localparam logic [FRAC_P:0] c_709_R = (FRAC_P+1)'((2126 * c_ONE + 5000) / 10000);
   localparam logic [FRAC_P:0] c_709_G = (FRAC_P+1)'((7152 * c_ONE + 5000) / 10000);
   localparam logic [FRAC_P:0] c_709_B = (FRAC_P+1)'(c_ONE - int'(c_709_R) - int'(c_709_G));
   localparam logic [FRAC_P:0] c_AVG_R = (FRAC_P+1)'((85 * c_ONE) / 256);
   localparam logic [FRAC_P:0] c_AVG_G = c_AVG_R;
   localparam logic [FRAC_P:0] c_AVG_B = (FRAC_P+1)'(c_ONE - 2 * int'(c_AVG_R));

   localparam logic [c_SUM_W:0] c_HALF = (c_SUM_W+1)'(1) << (FRAC_P - 1);
   localparam logic [1:0] c_MODE_601 = 2'd0;
   localparam logic [1:0] c_MODE_709 = 2'd1;
   localparam logic [1:0] c_MODE_AVG = 2'd2;

   logic                w_en;
   logic [FRAC_P:0]     w_coef_r, w_coef_g, w_coef_b;
   logic [c_SUM_W:0]    w_rnd;
   logic [c_SUM_W:0]    w_y;
   logic                w_sat;
   logic [WIDTH_P-1:0]  w_gray;

   logic                r_v1, r_v2, r_v3;
   logic [c_PROD_W-1:0] r_prod_r, r_prod_g, r_prod_b;
   logic [USER_W_P-1:0] r_user1, r_user2;
   logic [c_SUM_W-1:0]  r_sum;
   logic                r_sat;
   logic [15:0]         r_sat_cnt;

   assign w_en      = ~r_v3 | ready_i;
   assign ready_o   = w_en;
   assign valid_o   = r_v3;
   assign sat_cnt_o = r_sat_cnt;

   // Coefficient selection for the beat being accepted this cycle
   always_comb begin
      w_coef_r = coef_r_i;
      w_coef_g = coef_g_i;
      w_coef_b = coef_b_i;
      case (mode_i)
         c_MODE_601: begin w_coef_r = c_601_R; w_coef_g = c_601_G; w_coef_b = c_601_B; end
         c_MODE_709: begin w_coef_r = c_709_R; w_coef_g = c_709_G; w_coef_b = c_709_B; end
         c_MODE_AVG: begin w_coef_r = c_AVG_R; w_coef_g = c_AVG_G; w_coef_b = c_AVG_B; end
         default:    ;
      endcase
   end

   // Round half up, then clip anything above full scale
   always_comb begin
      w_rnd  = {1'b0, r_sum} + c_HALF;
      w_y    = w_rnd >> FRAC_P;
      w_sat  = |w_y[c_SUM_W:WIDTH_P];
      w_gray = w_sat ? {WIDTH_P{1'b1}} : w_y[WIDTH_P-1:0];
   end

   // Stage valid bits and output registers, all moving on the shared enable
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_v1   <= 1'b0;
         r_v2   <= 1'b0;
         r_v3   <= 1'b0;
         gray_o <= '0;
         user_o <= '0;
         r_sat  <= 1'b0;
      end else if (w_en) begin
         r_v1 <= valid_i & ready_o;
         r_v2 <= r_v1;
         r_v3 <= r_v2;
         if (r_v2) begin
            gray_o <= w_gray;
            user_o <= r_user2;
            r_sat  <= w_sat;
         end
      end
   end

   // Datapath stages S1 (products) and S2 (exact sum); no reset needed
   always_ff @(posedge clk_i) begin
      if (w_en) begin
         r_prod_r <= {{(FRAC_P+1){1'b0}}, red_i}   * {{WIDTH_P{1'b0}}, w_coef_r};
         r_prod_g <= {{(FRAC_P+1){1'b0}}, green_i} * {{WIDTH_P{1'b0}}, w_coef_g};
         r_prod_b <= {{(FRAC_P+1){1'b0}}, blue_i}  * {{WIDTH_P{1'b0}}, w_coef_b};
         r_user1  <= user_i;
         r_sum    <= {2'b00, r_prod_r} + {2'b00, r_prod_g} + {2'b00, r_prod_b};
         r_user2  <= r_user1;
      end
   end

   // Count clipped beats as they leave, sticking at the top value
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sat_cnt <= 16'd0;
      end else if (r_v3 && ready_i && r_sat && (r_sat_cnt != 16'hFFFF)) begin
         r_sat_cnt <= r_sat_cnt + 16'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rgb2luma_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb2luma_pipe
//  Description : Self-checking bench for rgb2luma_pipe (default parameters).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb2luma_pipe;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       valid_i, ready_o, valid_o, ready_i;
   logic [7:0] red_i, green_i, blue_i, gray_o;
   logic [0:0] user_i, user_o;
   logic [1:0] mode_i;
   logic [8:0] coef_r_i, coef_g_i, coef_b_i;
   logic [15:0] sat_cnt_o;

   int errors = 0;
   int checks = 0;
   int exp_sat = 0;

   rgb2luma_pipe #(.WIDTH_P(8), .FRAC_P(8), .USER_W_P(1)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .red_i(red_i), .green_i(green_i), .blue_i(blue_i), .user_i(user_i),
      .mode_i(mode_i), .coef_r_i(coef_r_i), .coef_g_i(coef_g_i), .coef_b_i(coef_b_i),
      .valid_o(valid_o), .ready_i(ready_i), .gray_o(gray_o), .user_o(user_o),
      .sat_cnt_o(sat_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference: weighted sum of the channels in 1/256 units, round half up.
   // Returns the unclipped value; callers clip at 255.
   function automatic int model_y(input int mode, input int r, input int g, input int b,
                                  input int cr, input int cg, input int cb);
      int kr, kg, kb;
      case (mode)
         0: begin kr = 77; kg = 150; kb = 29; end
         1: begin kr = 54; kg = 183; kb = 19; end
         2: begin kr = 85; kg = 85;  kb = 86; end
         default: begin kr = cr; kg = cg; kb = cb; end
      endcase
      return (r * kr + g * kg + b * kb + 128) / 256;
   endfunction

   task automatic set_beat(input int mode, input int r, input int g, input int b,
                           input int cr, input int cg, input int cb, input int u);
      valid_i  = 1'b1;
      mode_i   = 2'(mode);
      red_i    = 8'(r);
      green_i  = 8'(g);
      blue_i   = 8'(b);
      coef_r_i = 9'(cr);
      coef_g_i = 9'(cg);
      coef_b_i = 9'(cb);
      user_i   = 1'(u);
   endtask

   task automatic test_reset;
      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
      set_beat(0, 0, 0, 0, 0, 0, 0, 0); valid_i = 1'b0;
      #2;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_o: got %0b want 0", valid_o); end
      checks++; if (gray_o !== 8'd0) begin errors++; $display("FAIL reset_gray_o: got %0d want 0", gray_o); end
      checks++; if (user_o !== 1'b0) begin errors++; $display("FAIL reset_user_o: got %0b want 0", user_o); end
      checks++; if (sat_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_sat_cnt: got %0d want 0", sat_cnt_o); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_o: got %0b want 1", ready_o); end
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   // Modes 0,1,2 back to back on the same pixel; checks latency and values
   task automatic test_modes_back_to_back;
      int exp_g [3];
      for (int i = 0; i < 3; i++) exp_g[i] = model_y(i, 200, 100, 50, 0, 0, 0);
      @(negedge clk_i); ready_i = 1'b1;
      set_beat(0, 200, 100, 50, 0, 0, 0, 1);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk_i);
         if (c == 1) set_beat(1, 200, 100, 50, 0, 0, 0, 0);
         else if (c == 2) set_beat(2, 200, 100, 50, 0, 0, 0, 1);
         else valid_i = 1'b0;
         #1;
         if (c < 3 || c == 6) begin
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL latency_idle c%0d: valid_o got %0b want 0", c, valid_o); end
         end else begin
            checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL latency_valid c%0d: valid_o got %0b want 1", c, valid_o); end
            checks++; if (gray_o !== 8'(exp_g[c-3])) begin errors++; $display("FAIL mode%0d_gray: got %0d want %0d", c-3, gray_o, exp_g[c-3]); end
            checks++; if (user_o !== 1'((c == 4) ? 0 : 1)) begin errors++; $display("FAIL mode%0d_user: got %0b", c-3, user_o); end
         end
      end
      checks++; if (sat_cnt_o !== 16'(exp_sat)) begin errors++; $display("FAIL modes_sat_cnt: got %0d want %0d", sat_cnt_o, exp_sat); end
   endtask

   // Custom coefficients overflow; fixed modes at full scale do not
   task automatic test_saturation;
      @(negedge clk_i); ready_i = 1'b1;
      set_beat(3, 255, 255, 255, 256, 256, 0, 1);
      @(negedge clk_i);
      set_beat(0, 255, 255, 255, 0, 0, 0, 0);
      @(negedge clk_i); valid_i = 1'b0;
      @(negedge clk_i); #1;
      checks++; if (gray_o !== 8'd255 || valid_o !== 1'b1) begin errors++; $display("FAIL sat_custom_gray: got %0d/%0b want 255/1", gray_o, valid_o); end
      @(negedge clk_i); #1;
      exp_sat = exp_sat + 1;
      checks++; if (sat_cnt_o !== 16'(exp_sat)) begin errors++; $display("FAIL sat_custom_cnt: got %0d want %0d", sat_cnt_o, exp_sat); end
      checks++; if (gray_o !== 8'd255 || valid_o !== 1'b1) begin errors++; $display("FAIL sat_mode0_gray: got %0d/%0b want 255/1", gray_o, valid_o); end
      @(negedge clk_i); #1;
      checks++; if (sat_cnt_o !== 16'(exp_sat)) begin errors++; $display("FAIL sat_mode0_cnt: got %0d want %0d", sat_cnt_o, exp_sat); end
   endtask

   // Random stream with random downstream stalls, scoreboarded in order
   task automatic test_random_stall;
      int exp_gray [$];
      int exp_user [$];
      int exp_clip [$];
      int sent = 0, recv = 0, cyc = 0;
      int held_g = 0, held_u = 0;
      bit stalled = 0;
      int md, r, g, b, cr, cg, cb, u, y;
      while (recv < 10 && cyc < 400) begin
         @(negedge clk_i);
         cyc++;
         #1;
         if (stalled) begin
            checks++; if (gray_o !== 8'(held_g) || user_o !== 1'(held_u)) begin errors++; $display("FAIL stall_hold: got %0d/%0b want %0d/%0b", gray_o, user_o, held_g, held_u); end
         end
         if (sent < 10 && ($urandom_range(0, 3) != 0)) begin
            md = $urandom_range(0, 3); r = $urandom_range(0, 255); g = $urandom_range(0, 255);
            b = $urandom_range(0, 255); cr = $urandom_range(0, 511); cg = $urandom_range(0, 511);
            cb = $urandom_range(0, 511); u = $urandom_range(0, 1);
            set_beat(md, r, g, b, cr, cg, cb, u);
         end else begin
            valid_i = 1'b0;
         end
         ready_i = 1'($urandom_range(0, 1));
         #1;
         if (valid_i && ready_o) begin
            y = model_y(md, r, g, b, cr, cg, cb);
            exp_gray.push_back(y > 255 ? 255 : y);
            exp_clip.push_back(y > 255 ? 1 : 0);
            exp_user.push_back(u);
            sent++;
         end
         if (valid_o && ready_i) begin
            if (exp_gray.size() == 0) begin
               checks++; errors++; $display("FAIL stream_extra: unexpected output gray %0d", gray_o);
            end else begin
               checks++; if (gray_o !== 8'(exp_gray[0]) || user_o !== 1'(exp_user[0])) begin errors++; $display("FAIL stream_beat%0d: got %0d/%0b want %0d/%0b", recv, gray_o, user_o, exp_gray[0], exp_user[0]); end
               exp_sat = exp_sat + exp_clip[0];
               void'(exp_gray.pop_front()); void'(exp_user.pop_front()); void'(exp_clip.pop_front());
            end
            recv++;
         end
         stalled = valid_o && !ready_i;
         held_g = int'(gray_o); held_u = int'(user_o);
      end
      valid_i = 1'b0; ready_i = 1'b1;
      checks++; if (recv != 10 || sent != 10) begin errors++; $display("FAIL stream_count: got %0d outputs of %0d sent, want 10", recv, sent); end
      @(negedge clk_i); #1;
      checks++; if (sat_cnt_o !== 16'(exp_sat)) begin errors++; $display("FAIL stream_sat_cnt: got %0d want %0d", sat_cnt_o, exp_sat); end
   endtask

   // Reset with three beats in flight, then one fresh beat
   task automatic test_reset_midstream;
      int outs = 0, when = -1, got_g = -1;
      ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         set_beat(3, 255, 255, 255, 256, 256, 0, 1);
      end
      @(negedge clk_i);
      valid_i = 1'b0;
      rst_i = 1'b1;
      #1;
      exp_sat = 0;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %0b want 0", valid_o); end
      checks++; if (sat_cnt_o !== 16'd0) begin errors++; $display("FAIL midreset_sat_cnt: got %0d want 0", sat_cnt_o); end
      @(negedge clk_i); rst_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i); #1;
         if (valid_o) outs++;
      end
      checks++; if (outs != 0) begin errors++; $display("FAIL midreset_ghost: got %0d outputs want 0", outs); end
      set_beat(0, 200, 100, 50, 0, 0, 0, 1);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk_i);
         valid_i = 1'b0;
         #1;
         if (valid_o && ready_i) begin outs++; when = c; got_g = int'(gray_o); end
      end
      checks++; if (outs != 1 || when != 3) begin errors++; $display("FAIL midreset_single: got %0d outputs at cycle %0d want 1 at 3", outs, when); end
      checks++; if (got_g != model_y(0, 200, 100, 50, 0, 0, 0)) begin errors++; $display("FAIL midreset_gray: got %0d want %0d", got_g, model_y(0, 200, 100, 50, 0, 0, 0)); end
   endtask

   // Counter sticks at its top value
   task automatic test_sat_clamp;
      @(negedge clk_i);
      force dut.r_sat_cnt = 16'hFFFE;
      #1;
      release dut.r_sat_cnt;
      #1;
      checks++; if (sat_cnt_o !== 16'hFFFE) begin errors++; $display("FAIL clamp_preset: got %h want fffe", sat_cnt_o); end
      ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         set_beat(3, 255, 255, 255, 256, 256, 0, 0);
      end
      @(negedge clk_i); valid_i = 1'b0;
      repeat (4) @(negedge clk_i);
      #1;
      checks++; if (sat_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL clamp_top: got %h want ffff", sat_cnt_o); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         set_beat(3, 255, 255, 255, 256, 256, 0, 0);
      end
      @(negedge clk_i); valid_i = 1'b0;
      repeat (4) @(negedge clk_i);
      #1;
      checks++; if (sat_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL clamp_hold: got %h want ffff", sat_cnt_o); end
   endtask

   initial begin
      test_reset();
      test_modes_back_to_back();
      test_saturation();
      test_random_stall();
      test_random_stall();
      test_reset_midstream();
      test_sat_clamp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
